// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and sequencer state encodings for the UART TX path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int BYTE_W = 8;

  // Load sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAITB = 2'd2,
    ST_BUSY  = 2'd3
  } st_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port 2**AW x BYTE_W byte store, sync write, registered read.
// Latency: write visible to a read on the following edge; read data valid one edge after re.
// Backpressure: none; the owner guarantees we/re only on legal pointer positions.
// Ports: clk, rst (async, active high, clears the read register only),
//        we/waddr/wdata write port, re/raddr/rdata read port (rdata holds between reads).
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [0:(1<<AW)-1];

  // Array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register only advances on re, so rdata stays stable until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/uart_txfifo.sv
// uart_txfifo: byte FIFO plus load sequencer feeding uart_m (load/d/txbusy).
// Latency: byte pushed into an empty FIFO with the sequencer idle -> txload two cycles later.
// Backpressure: wr while full is dropped; draining paces on txbusy, one byte per uart_m frame.
// Ports: clk, rst (async, active high); host side wr/wd, full/empty;
//        UART side txload (1-cycle pulse), txd (stable from txload until next pop), txbusy;
//        level[AW:0] occupancy, present only when UART_TXFIFO_LEVEL_EN is defined.
module uart_txfifo
  import uart_pkg::*;
#(
  parameter int AW     = 4,
  parameter int BUSYTO = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [BYTE_W-1:0] wd,
  output logic              full,
  output logic              empty,
  output logic              txload,
  output logic [BYTE_W-1:0] txd,
  input  logic              txbusy
`ifdef UART_TXFIFO_LEVEL_EN
  ,
  output logic [AW:0]       level
`endif
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [7:0]  TMO_LAST = 8'(BUSYTO - 1);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  st_t           state;
  logic [7:0]    tmo;
  logic          push;
  logic          pop;

  // Flags come straight off the count register, no path from wr.
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

`ifdef UART_TXFIFO_LEVEL_EN
  assign level = cnt;
`endif

  // full is the pre-edge value, so a push at full is dropped even when a pop happens.
  assign push = wr && !full;
  assign pop  = (state == ST_IDLE) && !empty && !txbusy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Pop and push never touch the same slot: a pop needs cnt>=1 and a push needs cnt<depth.
  uart_fifo_mem #(
    .AW(AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wp),
    .wdata (wd),
    .re    (pop),
    .raddr (rp),
    .rdata (txd)
  );

  // Sequencer. txload is registered on the IDLE->LOAD edge so it is high only in LOAD.
  // WAITB has a timeout so a missing txbusy rise cannot stall the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      txload <= 1'b0;
      tmo    <= '0;
    end else begin
      txload <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state  <= ST_LOAD;
            txload <= 1'b1;
          end
        end
        ST_LOAD: begin
          state <= ST_WAITB;
          tmo   <= '0;
        end
        ST_WAITB: begin
          if (txbusy) begin
            state <= ST_BUSY;
          end else if (tmo == TMO_LAST) begin
            state <= ST_BUSY;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_BUSY: begin
          if (!txbusy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
